// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexes one 4-bit hex bus across NDIGITS common-anode digits.
// Each digit slot starts with a blanking gap. Digit values are staged in shadow
// registers and copied to the active set together at a frame boundary.
// Optional feature macro: DISPLAY_SCAN_PWM_EN adds per-frame brightness PWM on the enables.
module display_scan_ctrl #(
    parameter int unsigned  NDIGITS      = 2,
    parameter int unsigned  DWELL_CYCLES = 8,
    parameter int unsigned  BLANK_CYCLES = 1,
    parameter int unsigned  BRIGHT_BITS  = 3,
    localparam int unsigned IDXW         = $clog2(NDIGITS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDXW-1:0]    wr_idx,
    input  logic [3:0]         wr_data,
    input  logic               commit,
    output logic               commit_pending,
    output logic [3:0]         digit,
    output logic [NDIGITS-1:0] enable,
    output logic               frame_start
`ifdef DISPLAY_SCAN_PWM_EN
    ,
    input  logic [BRIGHT_BITS-1:0] brightness
`endif
);

    localparam int unsigned CNTW        = $clog2(DWELL_CYCLES);
    localparam int unsigned SHOW_CYCLES = DWELL_CYCLES - BLANK_CYCLES;

    // Elaboration-time parameter sanity checks
    if (NDIGITS < 2) begin : g_chk_ndigits
        $error("display_scan_ctrl: NDIGITS must be >= 2");
    end
    if ((BLANK_CYCLES < 1) || (BLANK_CYCLES >= DWELL_CYCLES)) begin : g_chk_blank
        $error("display_scan_ctrl: need 1 <= BLANK_CYCLES < DWELL_CYCLES");
    end
    if (BRIGHT_BITS < 1) begin : g_chk_bright
        $error("display_scan_ctrl: BRIGHT_BITS must be >= 1");
    end

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                   state_q, state_nxt;
    logic [CNTW-1:0]          cnt_q, cnt_nxt;
    logic [IDXW-1:0]          idx_q, idx_nxt;
    logic [NDIGITS-1:0][3:0]  shadow_q, shadow_nxt;
    logic [NDIGITS-1:0][3:0]  active_q, active_nxt;
    logic                     pending_nxt;
    logic                     last_cnt;
    logic                     last_idx;
    logic                     boundary;
    logic                     show_on;
    logic [3:0]               digit_nxt;
    logic [NDIGITS-1:0]       enable_nxt;
    logic                     frame_start_nxt;

`ifdef DISPLAY_SCAN_PWM_EN
    logic [BRIGHT_BITS-1:0]   bright_q;
    logic [31:0]              on_cycles;
`endif

    // Next-state, shadow/commit bookkeeping and next output values
    always_comb begin
        state_nxt       = state_q;
        cnt_nxt         = cnt_q;
        idx_nxt         = idx_q;
        shadow_nxt      = shadow_q;
        active_nxt      = active_q;
        pending_nxt     = commit_pending;
        show_on         = 1'b1;
        digit_nxt       = active_q[idx_q];
        enable_nxt      = '0;
        frame_start_nxt = 1'b0;

        last_cnt = (cnt_q == CNTW'(DWELL_CYCLES - 1));
        last_idx = (idx_q == IDXW'(NDIGITS - 1));
        boundary = (state_q == ST_SHOW) && last_cnt && last_idx;

        // slot sequencing: cnt wraps per slot, idx advances after SHOW
        cnt_nxt = last_cnt ? '0 : cnt_q + CNTW'(1);
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNTW'(BLANK_CYCLES - 1)) begin
                    state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (last_cnt) begin
                    state_nxt = ST_BLANK;
                    idx_nxt   = last_idx ? '0 : idx_q + IDXW'(1);
                end
            end
            default: state_nxt = ST_BLANK;
        endcase

        // shadow writes; indices beyond the last digit are accepted and dropped
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (wr_valid && wr_ready && (32'(wr_idx) == i)) begin
                shadow_nxt[IDXW'(i)] = wr_data;
            end
        end

        // commit: swap on the boundary if already pending, else arm
        if (boundary && commit_pending) begin
            active_nxt  = shadow_q;
            pending_nxt = 1'b0;
        end else if (commit && !commit_pending) begin
            pending_nxt = 1'b1;
        end

`ifdef DISPLAY_SCAN_PWM_EN
        on_cycles = ((32'(bright_q) + 32'd1) * SHOW_CYCLES) >> BRIGHT_BITS;
        show_on   = ((32'(cnt_q) - BLANK_CYCLES) < on_cycles);
`endif

        if ((state_q == ST_SHOW) && show_on) begin
            enable_nxt = NDIGITS'(1) << idx_q;
        end
        frame_start_nxt = (state_q == ST_BLANK) && (cnt_q == '0) && (idx_q == '0);
    end

    // State, storage and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_BLANK;
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_q       <= '0;
            active_q       <= '0;
            commit_pending <= 1'b0;
            wr_ready       <= 1'b0;
            digit          <= '0;
            enable         <= '0;
            frame_start    <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            cnt_q          <= cnt_nxt;
            idx_q          <= idx_nxt;
            shadow_q       <= shadow_nxt;
            active_q       <= active_nxt;
            commit_pending <= pending_nxt;
            wr_ready       <= !pending_nxt;
            digit          <= digit_nxt;
            enable         <= enable_nxt;
            frame_start    <= frame_start_nxt;
        end
    end

`ifdef DISPLAY_SCAN_PWM_EN
    // Brightness is captured once per frame so a frame never changes duty mid-way
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright_q <= '0;
        end else if (frame_start_nxt) begin
            bright_q <= brightness;
        end
    end
`endif

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed bench for display_scan_ctrl with a per-edge scoreboard
// of expected {frame_start, enable, digit}; pending/ready checked at directed points.
module tb_display_scan_ctrl;

    localparam int unsigned SHOW_N = 7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [0:0] wr_idx;
    logic [3:0] wr_data;
    logic       commit;
    logic       commit_pending;
    logic [3:0] digit;
    logic [1:0] enable;
    logic       frame_start;
`ifdef DISPLAY_SCAN_PWM_EN
    logic [2:0] brightness;
`endif

    typedef struct packed {
        logic       fs;
        logic [1:0] en;
        logic [3:0] dg;
    } exp_t;

    exp_t sb_q[$];
    int   checks  = 0;
    int   passes  = 0;
    int   fails   = 0;
    int   edge_no = 0;

    display_scan_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_idx         (wr_idx),
        .wr_data        (wr_data),
        .commit         (commit),
        .commit_pending (commit_pending),
        .digit          (digit),
        .enable         (enable),
        .frame_start    (frame_start)
`ifdef DISPLAY_SCAN_PWM_EN
        ,
        .brightness     (brightness)
`endif
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for one 16-edge frame: slot = p/8, blank at p%8==0
    task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1, input int on);
        exp_t e;
        int   slot;
        int   k;
        for (int p = 0; p < 16; p++) begin
            slot = p / 8;
            k    = p % 8;
            e.fs = (p == 0);
            e.dg = (slot == 0) ? d0 : d1;
            e.en = ((k >= 1) && ((k - 1) < on)) ? ((slot == 0) ? 2'b01 : 2'b10) : 2'b00;
            sb_q.push_back(e);
        end
    endtask

    // Advance n edges, sampling #1 after each and comparing against the scoreboard
    task automatic step(input int n);
        exp_t e;
        exp_t o;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_no++;
            o.fs = frame_start;
            o.en = enable;
            o.dg = digit;
            e    = sb_q.pop_front();
            chk($sformatf("scan_edge%0d", edge_no), 32'(o), 32'(e));
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        commit   = 1'b0;
`ifdef DISPLAY_SCAN_PWM_EN
        brightness = 3'd7;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_pending", 32'(commit_pending), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // frame 0 (edges 1..16): idle scan, digit 0
        push_frame(4'h0, 4'h0, SHOW_N);
        step(1);
        chk("ready_after_release", 32'(wr_ready), 32'd1);
        chk("pending_after_release", 32'(commit_pending), 32'd0);
        step(15);

        // frame 1 (17..32): stage 5/A, commit at edge 20
        push_frame(4'h0, 4'h0, SHOW_N);
        wr_valid = 1'b1; wr_idx = 1'b0; wr_data = 4'h5;
        step(1);
        wr_idx = 1'b1; wr_data = 4'hA;
        step(1);
        wr_valid = 1'b0;
        step(1);
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        chk("pending_set", 32'(commit_pending), 32'd1);
        chk("ready_low_pending", 32'(wr_ready), 32'd0);
        step(11);
        chk("pending_before_boundary", 32'(commit_pending), 32'd1);
        step(1);
        chk("pending_clr_boundary", 32'(commit_pending), 32'd0);
        chk("ready_back_boundary", 32'(wr_ready), 32'd1);

        // frame 2 (33..48): shows 5/A; blocked write of 3 and a repeated commit while pending
        push_frame(4'h5, 4'hA, SHOW_N);
        step(1);
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        chk("pending_set2", 32'(commit_pending), 32'd1);
        chk("ready_low2", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1; wr_idx = 1'b0; wr_data = 4'h3;
        step(1);
        wr_valid = 1'b0;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        chk("pending_hold_recommit", 32'(commit_pending), 32'd1);
        step(12);
        chk("pending_clr2", 32'(commit_pending), 32'd0);

        // frame 3 (49..64): still 5/A; stage 1/2, commit on the boundary edge 64
        push_frame(4'h5, 4'hA, SHOW_N);
        wr_valid = 1'b1; wr_idx = 1'b0; wr_data = 4'h1;
        step(1);
        wr_idx = 1'b1; wr_data = 4'h2;
        step(1);
        wr_valid = 1'b0;
        step(13);
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        chk("pending_boundary_commit", 32'(commit_pending), 32'd1);

        // frame 4 (65..80): old values held one more frame, swap at 80
        push_frame(4'h5, 4'hA, SHOW_N);
        step(15);
        chk("pending_extra_frame", 32'(commit_pending), 32'd1);
        step(1);
        chk("pending_clr_late", 32'(commit_pending), 32'd0);

        // frame 5 (81..96): shows 1/2; write idx1=7 in the same cycle as commit
        push_frame(4'h1, 4'h2, SHOW_N);
        step(1);
        wr_valid = 1'b1; wr_idx = 1'b1; wr_data = 4'h7; commit = 1'b1;
        step(1);
        wr_valid = 1'b0; commit = 1'b0;
        chk("pending_wr_commit", 32'(commit_pending), 32'd1);
        step(14);

        // frame 6 (97..112): shows 1/7; commit again, then reset during idx1 SHOW
        push_frame(4'h1, 4'h7, SHOW_N);
        wr_valid = 1'b1; wr_idx = 1'b0; wr_data = 4'h9; commit = 1'b1;
        step(1);
        wr_valid = 1'b0; commit = 1'b0;
        step(11);
        chk("pending_before_reset", 32'(commit_pending), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_enable", 32'(enable), 32'd0);
        chk("async_rst_digit", 32'(digit), 32'd0);
        chk("async_rst_pending", 32'(commit_pending), 32'd0);
        chk("async_rst_wr_ready", 32'(wr_ready), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        edge_no = 0;

        // two frames after reset: idle pattern, digit 0, dropped commit never lands
        push_frame(4'h0, 4'h0, SHOW_N);
        step(16);
        chk("pending_after_rst", 32'(commit_pending), 32'd0);
        chk("ready_after_rst", 32'(wr_ready), 32'd1);
        push_frame(4'h0, 4'h0, SHOW_N);
        step(16);

`ifdef DISPLAY_SCAN_PWM_EN
        // brightness changes mid-frame only take effect from the next frame_start
        push_frame(4'h0, 4'h0, SHOW_N);
        step(5);
        brightness = 3'd3;
        step(11);
        push_frame(4'h0, 4'h0, 3);
        step(16);
        push_frame(4'h0, 4'h0, 3);
        step(4);
        brightness = 3'd0;
        step(12);
        push_frame(4'h0, 4'h0, 0);
        step(16);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
